// File: rtl/antenna_ook_tx.sv
// -----------------------------------------------------------------------------
// antenna_ook_tx
//   Transmit sequencer for the on-chip antenna. Accepts one payload word per
//   valid/ready handshake and sends it as a frame: PRE_W preamble bits, then
//   DATA_W payload bits (MSB first), then GAP_CYCLES silent cycles. Each bit
//   lasts BIT_CYCLES cycles and is on-off keyed: a '1' is a square-wave carrier
//   that starts high with a CARRIER_HALF half-period, and a '0' stays low. The
//   carrier phase restarts at every bit boundary.
//
// Ports
//   i_clk         system clock
//   i_rst_n       synchronous active-low reset
//   i_enable      transmitter enable; low while busy aborts the frame
//   i_s_valid     source word valid
//   o_s_ready     block can accept a word (enable && idle)
//   i_s_data      payload word
//   o_ant_drive   registered excitation for the antenna input
//   o_busy        frame in progress
//   o_bit_strobe  pulse on the first cycle of every preamble/data bit
//   o_frame_done  pulse in the first idle cycle after a completed frame
//   o_aborted     pulse in the first idle cycle after an aborted frame
// -----------------------------------------------------------------------------
module antenna_ook_tx #(
    parameter int unsigned      DATA_W       = 8,
    parameter int unsigned      PRE_W        = 8,
    parameter logic [PRE_W-1:0] PRE_PATTERN  = 8'b10101010,
    parameter int unsigned      BIT_CYCLES   = 1024,
    parameter int unsigned      CARRIER_HALF = 4,
    parameter int unsigned      GAP_CYCLES   = 2048
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [DATA_W-1:0] i_s_data,
    output logic              o_ant_drive,
    output logic              o_busy,
    output logic              o_bit_strobe,
    output logic              o_frame_done,
    output logic              o_aborted
);

    localparam int unsigned MAX_BITS = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int unsigned CNT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int unsigned K_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned HALF_W   = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam int unsigned G_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [K_W-1:0]    K_LAST    = K_W'(BIT_CYCLES - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CARRIER_HALF - 1);
    localparam logic [G_W-1:0]    G_LAST    = G_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]        r_state, w_state_d;
    logic [K_W-1:0]    r_k, w_k_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;        // bits remaining in current phase, minus one
    logic [G_W-1:0]    r_gap, w_gap_d;
    logic [PRE_W-1:0]  r_pre, w_pre_d;        // preamble shift register, MSB is current bit
    logic [DATA_W-1:0] r_data, w_data_d;      // payload shift register, MSB is current bit
    logic [HALF_W-1:0] r_half, w_half_d;      // position within a carrier half-period
    logic              r_low, w_low_d;        // carrier in its low half
    logic              r_ant, w_ant_d;
    logic              r_done, w_done_d;
    logic              r_abort, w_abort_d;
    logic              w_bit_d;

    always_comb begin
        w_state_d = r_state;
        w_k_d     = r_k;
        w_cnt_d   = r_cnt;
        w_gap_d   = r_gap;
        w_pre_d   = r_pre;
        w_data_d  = r_data;
        w_done_d  = 1'b0;
        w_abort_d = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_enable && i_s_valid) begin
                    w_state_d = ST_PRE;
                    w_k_d     = '0;
                    w_cnt_d   = PRE_LAST;
                    w_pre_d   = PRE_PATTERN;
                    w_data_d  = i_s_data;
                end
            end
            ST_PRE, ST_DATA: begin
                if (r_k == K_LAST) begin
                    w_k_d = '0;
                    if (r_cnt != '0) begin
                        w_cnt_d = r_cnt - 1'b1;
                        if (r_state == ST_PRE) begin
                            w_pre_d = r_pre << 1;
                        end else begin
                            w_data_d = r_data << 1;
                        end
                    end else if (r_state == ST_PRE) begin
                        w_state_d = ST_DATA;
                        w_cnt_d   = DATA_LAST;
                    end else if (GAP_CYCLES == 0) begin
                        w_state_d = ST_IDLE;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = ST_GAP;
                        w_gap_d   = '0;
                    end
                end else begin
                    w_k_d = r_k + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap == G_LAST) begin
                    w_state_d = ST_IDLE;
                    w_done_d  = 1'b1;
                end else begin
                    w_gap_d = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Abort wins over any normal progression, including a completing frame.
        if (!i_enable && (r_state != ST_IDLE)) begin
            w_state_d = ST_IDLE;
            w_done_d  = 1'b0;
            w_abort_d = 1'b1;
        end

        // Carrier phase is derived from the next-cycle k so the registered
        // ant_drive lines up with the cycle the new bit is presented.
        if (w_k_d == '0) begin
            w_half_d = '0;
            w_low_d  = 1'b0;
        end else if (r_half == HALF_LAST) begin
            w_half_d = '0;
            w_low_d  = ~r_low;
        end else begin
            w_half_d = r_half + 1'b1;
            w_low_d  = r_low;
        end

        w_bit_d = 1'b0;
        if (w_state_d == ST_PRE) begin
            w_bit_d = w_pre_d[PRE_W-1];
        end else if (w_state_d == ST_DATA) begin
            w_bit_d = w_data_d[DATA_W-1];
        end
        w_ant_d = w_bit_d & ~w_low_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_pre   <= '0;
            r_data  <= '0;
            r_half  <= '0;
            r_low   <= 1'b0;
            r_ant   <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_k     <= w_k_d;
            r_cnt   <= w_cnt_d;
            r_gap   <= w_gap_d;
            r_pre   <= w_pre_d;
            r_data  <= w_data_d;
            r_half  <= w_half_d;
            r_low   <= w_low_d;
            r_ant   <= w_ant_d;
            r_done  <= w_done_d;
            r_abort <= w_abort_d;
        end
    end

    assign o_s_ready    = i_enable && (r_state == ST_IDLE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_bit_strobe = ((r_state == ST_PRE) || (r_state == ST_DATA)) && (r_k == '0);
    assign o_ant_drive  = r_ant;
    assign o_frame_done = r_done;
    assign o_aborted    = r_abort;

endmodule

// File: tb/tb_antenna_ook_tx.sv
// -----------------------------------------------------------------------------
// tb_antenna_ook_tx
//   Directed bench for antenna_ook_tx. Stimulus pushes the expected bit values
//   and frame-end events into queues; a negedge monitor pops them on every
//   bit_strobe (checking the 8-cycle ant_drive waveform of that bit) and on
//   every frame_done/aborted pulse (checking the kind and the busy length).
//   A second instance built with GAP_CYCLES=0 checks the no-gap frame length.
// -----------------------------------------------------------------------------
module tb_antenna_ook_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, s_valid, s_ready;
    logic [7:0] s_data;
    logic       ant, busy, strobe, done, aborted;
    logic       en1, v1, rdy1;
    logic [7:0] d1;
    logic       ant1, busy1, strb1, done1, ab1;

    always #5 clk = ~clk;

    antenna_ook_tx #(
        .DATA_W(8), .PRE_W(4), .PRE_PATTERN(4'b1010),
        .BIT_CYCLES(8), .CARRIER_HALF(2), .GAP_CYCLES(4)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_s_valid(s_valid),
        .o_s_ready(s_ready), .i_s_data(s_data), .o_ant_drive(ant), .o_busy(busy),
        .o_bit_strobe(strobe), .o_frame_done(done), .o_aborted(aborted)
    );

    antenna_ook_tx #(
        .DATA_W(8), .PRE_W(4), .PRE_PATTERN(4'b1010),
        .BIT_CYCLES(8), .CARRIER_HALF(2), .GAP_CYCLES(0)
    ) u_dut_nogap (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en1), .i_s_valid(v1),
        .o_s_ready(rdy1), .i_s_data(d1), .o_ant_drive(ant1), .o_busy(busy1),
        .o_bit_strobe(strb1), .o_frame_done(done1), .o_aborted(ab1)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    logic q_bits[$];
    bit   q_end_kind[$];   // 0 = frame_done, 1 = aborted
    int   q_end_len[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] d, input int ndata);
        logic [3:0] pre;
        pre = 4'b1010;
        for (int i = 3; i >= 0; i--) q_bits.push_back(pre[i]);
        for (int i = 7; i >= 8 - ndata; i--) q_bits.push_back(d[i]);
    endtask

    task automatic push_end(input bit kind, input int len);
        q_end_kind.push_back(kind);
        q_end_len.push_back(len);
    endtask

    // Caller is idle-enabled at posedge+1; returns in cycle 0 of the frame.
    task automatic send(input logic [7:0] d);
        s_data  = d;
        s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
    endtask

    // Monitor / scoreboard
    logic       cap_on = 1'b0;
    int         cap_pos = 0;
    logic [7:0] cap_ant;
    logic       exp_bit;
    int         busy_len = 0;
    logic [7:0] one_pat = 8'b11001100;
    bit         e_kind;
    int         e_len;

    always @(negedge clk) begin
        if (!rst_n) begin
            cap_on   = 1'b0;
            cap_pos  = 0;
            busy_len = 0;
        end else begin
            if (done || aborted) begin
                check("end_expected", 32'(q_end_kind.size() > 0), 1);
                if (q_end_kind.size() > 0) begin
                    e_kind = q_end_kind.pop_front();
                    e_len  = q_end_len.pop_front();
                    check("end_kind", 32'({done, aborted}), e_kind ? 1 : 2);
                    check("end_busy_len", busy_len, e_len);
                end
                if (aborted) cap_on = 1'b0;
            end
            busy_len = (busy === 1'b1) ? busy_len + 1 : 0;
            if (strobe) begin
                check("strobe_spacing", 32'(cap_on), 0);
                check("bit_expected", 32'(q_bits.size() > 0), 1);
                if (q_bits.size() > 0) begin
                    exp_bit = q_bits.pop_front();
                    cap_on  = 1'b1;
                    cap_pos = 0;
                    cap_ant = '0;
                end
            end
            if (cap_on) begin
                cap_ant = {cap_ant[6:0], ant};
                cap_pos++;
                if (cap_pos == 8) begin
                    check("bit_waveform", 32'(cap_ant), 32'(exp_bit ? one_pat : 8'h00));
                    cap_on = 1'b0;
                end
            end
        end
    end

    int n, n_strb;

    initial begin
        rst_n = 1'b0; en = 1'b1; s_valid = 1'b0; s_data = '0;
        en1 = 1'b1; v1 = 1'b0; d1 = '0;

        // Reset
        tick(3);
        check("rst_ant", 32'(ant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_strobe", 32'(strobe), 0);
        check("rst_done", 32'(done), 0);
        check("rst_aborted", 32'(aborted), 0);
        check("rst_s_ready", 32'(s_ready), 1);
        rst_n = 1'b1;
        tick(3);
        check("idle_busy", 32'(busy), 0);
        check("idle_ant", 32'(ant), 0);

        // Single frame
        push_frame(8'hA5, 8);
        push_end(0, 100);
        send(8'hA5);
        check("first_cycle_ant", 32'(ant), 1);
        check("first_cycle_strobe", 32'(strobe), 1);
        tick(99);
        check("last_busy", 32'(busy), 1);
        check("gap_ant", 32'(ant), 0);
        check("done_not_early", 32'(done), 0);
        tick(1);
        check("frame_done_cycle", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        tick(1);
        check("done_one_cycle", 32'(done), 0);

        // Back-to-back with s_valid held high
        tick(2);
        push_frame(8'hFF, 8);
        push_end(0, 100);
        push_frame(8'h00, 8);
        push_end(0, 100);
        s_data = 8'hFF; s_valid = 1'b1;
        tick(1);
        s_data = 8'h00;
        tick(100);
        check("b2b_done", 32'(done), 1);
        check("b2b_ready", 32'(s_ready), 1);
        tick(1);
        s_valid = 1'b0;
        check("b2b_second_busy", 32'(busy), 1);
        check("b2b_second_strobe", 32'(strobe), 1);
        tick(100);
        check("b2b_second_done", 32'(done), 1);

        // Abort during data bit 3, k=5
        tick(2);
        push_frame(8'hB4, 4);
        push_end(1, 62);
        send(8'hB4);
        tick(61);
        check("pre_abort_ant", 32'(ant), 1);
        en = 1'b0;
        tick(1);
        check("abort_ant", 32'(ant), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_pulse", 32'(aborted), 1);
        check("abort_no_done", 32'(done), 0);
        check("abort_ready_low", 32'(s_ready), 0);
        tick(1);
        check("abort_one_cycle", 32'(aborted), 0);
        en = 1'b1;
        #1;
        check("abort_ready_back", 32'(s_ready), 1);
        tick(1);
        push_frame(8'h96, 8);
        push_end(0, 100);
        send(8'h96);
        tick(100);
        check("post_abort_done", 32'(done), 1);

        // Reset during GAP
        tick(2);
        push_frame(8'h3C, 8);
        send(8'h3C);
        tick(97);
        check("gap_busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick(1);
        check("mrst_ant", 32'(ant), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(done), 0);
        check("mrst_aborted", 32'(aborted), 0);
        tick(1);
        rst_n = 1'b1;
        tick(5);
        check("mrst_idle", 32'(busy), 0);
        push_frame(8'h5A, 8);
        push_end(0, 100);
        send(8'h5A);
        tick(100);
        check("post_rst_done", 32'(done), 1);

        // GAP_CYCLES = 0 build
        tick(2);
        d1 = 8'hC3; v1 = 1'b1;
        tick(1);
        v1 = 1'b0;
        check("nogap_first_ant", 32'(ant1), 1);
        n = 0;
        n_strb = 0;
        while (busy1 === 1'b1 && n < 200) begin
            if (strb1 === 1'b1) n_strb++;
            n++;
            tick(1);
        end
        check("nogap_busy_len", n, 96);
        check("nogap_strobes", n_strb, 12);
        check("nogap_done_direct", 32'(done1), 1);

        tick(5);
        check("bits_drained", q_bits.size(), 0);
        check("ends_drained", q_end_kind.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
